// File: rtl/adc_spi_responder_if.sv
// SPI pin bundle between an ADC reader (master) and the emulated ADC (slave).
// No valid/ready here: cs_n low frames a transfer, the master drives din and
// changes nothing but sclk edges; the slave changes dout only after sclk falls.
interface adc_spi_responder_if;
  logic sclk;
  logic cs_n;
  logic din;
  logic dout;
  logic dout_oe;

  modport master (output sclk, output cs_n, output din, input dout, input dout_oe);
  modport slave  (input sclk, input cs_n, input din, output dout, output dout_oe);
endinterface

// File: rtl/adc_spi_responder.sv
// Emulated 8-channel 12-bit SPI ADC: decodes start/SGL/D2..D0 on din and
// returns null + DATA_W bits MSB first, all pins oversampled on clk.
module adc_spi_responder #(
  parameter int DATA_W      = 12,
  parameter int NCH         = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  adc_spi_responder_if.slave      spi,
  input  logic [NCH*DATA_W-1:0]   sample_bus,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    frame_err,
  output logic [$clog2(NCH)-1:0]  last_ch,
  output logic                    last_sgl,
  output logic [2:0]              dbg_state
);
  localparam int CH_W  = $clog2(NCH);
  localparam int IDX_W = $clog2(DATA_W);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_START, S_CMD, S_SAMPLE, S_NULLB, S_DATA, S_TRAIL
  } state_t;

  // cs_n synchroniser resets high so reset release never looks like a select
  logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_din_sync;
  logic                   r_sclk_d;
  logic                   w_sclk_s, w_cs_s, w_din_s, w_rise, w_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_din_sync  <= '0;
      r_sclk_d    <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi.sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi.cs_n};
      r_din_sync  <= {r_din_sync[SYNC_STAGES-2:0], spi.din};
      r_sclk_d    <= w_sclk_s;
    end
  end

  assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
  assign w_din_s  = r_din_sync[SYNC_STAGES-1];
  assign w_rise   = w_sclk_s & ~r_sclk_d;
  assign w_fall   = ~w_sclk_s & r_sclk_d;

  logic [DATA_W-1:0] w_ch_val [NCH];
  logic [3:0]        w_cmd;
  logic [CH_W-1:0]   w_ch;
  logic              w_sgl;
  logic [DATA_W-1:0] w_a, w_b, w_sample;
  logic [2:0]        r_cmd;

  always_comb begin
    for (int k = 0; k < NCH; k++) w_ch_val[k] = sample_bus[k*DATA_W +: DATA_W];
  end

  // Differential reading pairs channel ch with ch^1 and clamps negatives to 0
  assign w_cmd    = {r_cmd, w_din_s};
  assign w_sgl    = w_cmd[3];
  assign w_ch     = w_cmd[CH_W-1:0];
  assign w_a      = w_ch_val[w_ch];
  assign w_b      = w_ch_val[w_ch ^ CH_W'(1)];
  assign w_sample = w_sgl ? w_a : ((w_a > w_b) ? (w_a - w_b) : '0);

  state_t            r_state, w_state_n;
  logic [1:0]        r_cnt, w_cnt_n;
  logic [2:0]        w_cmd_n;
  logic [IDX_W-1:0]  r_idx, w_idx_n;
  logic [DATA_W-1:0] r_shift, w_shift_n;
  logic              r_dout, w_dout_n, r_oe, w_oe_n, r_busy, w_busy_n;
  logic              r_done, w_done_n, r_err, w_err_n, r_tdone, w_tdone_n;
  logic [CH_W-1:0]   r_last_ch, w_last_ch_n;
  logic              r_last_sgl, w_last_sgl_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_cmd      <= '0;
      r_idx      <= '0;
      r_shift    <= '0;
      r_dout     <= 1'b0;
      r_oe       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_tdone    <= 1'b0;
      r_last_ch  <= '0;
      r_last_sgl <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_cnt      <= w_cnt_n;
      r_cmd      <= w_cmd_n;
      r_idx      <= w_idx_n;
      r_shift    <= w_shift_n;
      r_dout     <= w_dout_n;
      r_oe       <= w_oe_n;
      r_busy     <= w_busy_n;
      r_done     <= w_done_n;
      r_err      <= w_err_n;
      r_tdone    <= w_tdone_n;
      r_last_ch  <= w_last_ch_n;
      r_last_sgl <= w_last_sgl_n;
    end
  end

  always_comb begin
    w_state_n    = r_state;
    w_cnt_n      = r_cnt;
    w_cmd_n      = r_cmd;
    w_idx_n      = r_idx;
    w_shift_n    = r_shift;
    w_dout_n     = r_dout;
    w_oe_n       = r_oe;
    w_busy_n     = r_busy;
    w_done_n     = 1'b0;
    w_err_n      = 1'b0;
    w_tdone_n    = r_tdone;
    w_last_ch_n  = r_last_ch;
    w_last_sgl_n = r_last_sgl;
    if (w_cs_s) begin
      w_state_n = S_IDLE;
      w_oe_n    = 1'b0;
      w_dout_n  = 1'b0;
      w_busy_n  = 1'b0;
      w_err_n   = (r_state == S_CMD) || (r_state == S_SAMPLE) ||
                  (r_state == S_NULLB) || (r_state == S_DATA);
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_n = S_WAIT_START;
          w_busy_n  = 1'b1;
          w_oe_n    = 1'b1;
          w_dout_n  = 1'b0;
          w_tdone_n = 1'b0;
        end
        S_WAIT_START: if (w_rise && w_din_s) begin
          w_state_n = S_CMD;
          w_cnt_n   = '0;
        end
        S_CMD: if (w_rise) begin
          w_cmd_n = w_cmd[2:0];
          w_cnt_n = r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            w_last_sgl_n = w_sgl;
            w_last_ch_n  = w_ch;
            w_shift_n    = w_sample;
            w_state_n    = S_SAMPLE;
          end
        end
        S_SAMPLE: if (w_fall) w_state_n = S_NULLB;
        S_NULLB: if (w_fall) begin
          w_dout_n  = 1'b0;
          w_idx_n   = IDX_W'(DATA_W - 1);
          w_state_n = S_DATA;
        end
        S_DATA: if (w_fall) begin
          w_dout_n = r_shift[r_idx];
          if (r_idx == '0) w_state_n = S_TRAIL;
          else             w_idx_n   = r_idx - IDX_W'(1);
        end
        S_TRAIL: if (w_fall && !r_tdone) begin
          w_done_n  = 1'b1;
          w_tdone_n = 1'b1;
          w_dout_n  = 1'b0;
        end
        default: w_state_n = S_IDLE;
      endcase
    end
  end

  assign spi.dout    = r_dout;
  assign spi.dout_oe = r_oe;
  assign busy        = r_busy;
  assign frame_done  = r_done;
  assign frame_err   = r_err;
  assign last_ch     = r_last_ch;
  assign last_sgl    = r_last_sgl;
  assign dbg_state   = r_state;
endmodule

// File: tb/tb_adc_spi_responder.sv
// Bench for adc_spi_responder: a table of directed frames, corner sequences
// and random frames checked against an arithmetic model of the ADC reading.
module tb_adc_spi_responder;
  localparam int DATA_W = 12;
  localparam int NCH    = 8;
  localparam int HALF   = 5;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adc_spi_responder_if spi_if();
  logic [NCH*DATA_W-1:0] sample_bus;
  logic busy, frame_done, frame_err, last_sgl;
  logic [2:0] last_ch, dbg_state;

  adc_spi_responder dut (
    .clk(clk), .rst_n(rst_n), .spi(spi_if), .sample_bus(sample_bus),
    .busy(busy), .frame_done(frame_done), .frame_err(frame_err),
    .last_ch(last_ch), .last_sgl(last_sgl), .dbg_state(dbg_state)
  );

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  logic [DATA_W-1:0] exp_q[$];

  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    if (frame_err)  err_cnt++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // ADC reading from the channel-value rules, plain integer arithmetic
  function automatic logic [DATA_W-1:0] model(input logic [NCH*DATA_W-1:0] bus,
                                              input logic sgl, input int ch);
    int a, b;
    a = int'(bus[ch*DATA_W +: DATA_W]);
    b = int'(bus[(ch ^ 1)*DATA_W +: DATA_W]);
    if (sgl) return DATA_W'(a);
    return (a > b) ? DATA_W'(a - b) : '0;
  endfunction

  task automatic set_ch(input int ch, input logic [DATA_W-1:0] v);
    sample_bus[ch*DATA_W +: DATA_W] = v;
  endtask

  task automatic rand_bus();
    for (int k = 0; k < NCH; k++) sample_bus[k*DATA_W +: DATA_W] = DATA_W'($urandom_range(0, 4095));
  endtask

  // driver tasks
  task automatic half();
    repeat (HALF) @(negedge clk);
  endtask

  task automatic pulse(input logic d, output logic q);
    spi_if.din = d;
    half();
    spi_if.sclk = 1'b1;
    q = spi_if.dout;
    half();
    spi_if.sclk = 1'b0;
  endtask

  task automatic send_cmd(input int lead, input logic sgl, input int ch);
    logic q;
    logic [2:0] c;
    c = 3'(ch);
    for (int i = 0; i < lead; i++) pulse(1'b0, q);
    pulse(1'b1, q);
    pulse(sgl, q);
    pulse(c[2], q);
    pulse(c[1], q);
    pulse(c[0], q);
    spi_if.din = 1'b0;
  endtask

  // one frame; nbits < DATA_W aborts by raising cs_n mid-data
  task automatic run_frame(input int lead, input logic sgl, input int ch, input int nbits,
                           input string tag);
    int d0, e0;
    logic q, s0, nb;
    logic [DATA_W-1:0] got, expv;
    expv = exp_q.pop_front();
    d0 = done_cnt;
    e0 = err_cnt;
    spi_if.cs_n = 1'b0;
    repeat (4) @(negedge clk);
    check({tag, " oe_on"}, 32'(spi_if.dout_oe), 32'd1);
    check({tag, " busy_on"}, 32'(busy), 32'd1);
    send_cmd(lead, sgl, ch);
    rand_bus();
    pulse(1'b0, s0);
    pulse(1'b0, nb);
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      pulse(1'b0, q);
      got = {got[DATA_W-2:0], q};
    end
    repeat (2*HALF) @(negedge clk);
    spi_if.cs_n = 1'b1;
    repeat (4) @(negedge clk);
    check({tag, " sample_bit"}, 32'(s0), 32'd0);
    check({tag, " null_bit"}, 32'(nb), 32'd0);
    check({tag, " data"}, 32'(got), 32'(expv >> (DATA_W - nbits)));
    check({tag, " done"}, 32'(done_cnt - d0), (nbits == DATA_W) ? 32'd1 : 32'd0);
    check({tag, " err"}, 32'(err_cnt - e0), (nbits == DATA_W) ? 32'd0 : 32'd1);
    check({tag, " last_ch"}, 32'(last_ch), 32'(ch));
    check({tag, " last_sgl"}, 32'(last_sgl), 32'(sgl));
    check({tag, " oe_off"}, 32'(spi_if.dout_oe), 32'd0);
    check({tag, " busy_off"}, 32'(busy), 32'd0);
    check({tag, " dout_idle"}, 32'(spi_if.dout), 32'd0);
  endtask

  typedef struct {
    int               lead;
    logic             sgl;
    int               ch;
    logic [DATA_W-1:0] v_ch;
    logic [DATA_W-1:0] v_par;
    logic [DATA_W-1:0] expv;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic q;
    int bad, d0, e0, lead, ch;
    logic sgl;

    vecs[0] = '{0, 1'b1, 5, 12'hA5C, 12'h123, 12'hA5C};
    vecs[1] = '{0, 1'b0, 2, 12'h300, 12'h100, 12'h200};
    vecs[2] = '{0, 1'b0, 2, 12'h100, 12'h300, 12'h000};
    vecs[3] = '{3, 1'b1, 0, 12'hFFF, 12'h000, 12'hFFF};
    vecs[4] = '{1, 1'b0, 7, 12'h800, 12'h7FF, 12'h001};
    vecs[5] = '{2, 1'b0, 3, 12'h555, 12'h555, 12'h000};

    spi_if.sclk = 1'b0;
    spi_if.cs_n = 1'b1;
    spi_if.din  = 1'b0;
    sample_bus  = '0;
    repeat (3) @(negedge clk);
    check("reset dout", 32'(spi_if.dout), 32'd0);
    check("reset oe", 32'(spi_if.dout_oe), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset last_ch", 32'(last_ch), 32'd0);
    check("reset last_sgl", 32'(last_sgl), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // sclk activity while deselected
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      spi_if.din = 1'($urandom_range(0, 1));
      half();
      spi_if.sclk = ~spi_if.sclk;
      if (spi_if.dout_oe || busy) bad++;
    end
    spi_if.sclk = 1'b0;
    repeat (6) @(negedge clk);
    check("idle sclk oe/busy", 32'(bad), 32'd0);
    check("idle sclk pulses", 32'(done_cnt + err_cnt), 32'd0);

    for (int v = 0; v < 6; v++) begin
      rand_bus();
      set_ch(vecs[v].ch, vecs[v].v_ch);
      set_ch(vecs[v].ch ^ 1, vecs[v].v_par);
      exp_q.push_back(vecs[v].expv);
      run_frame(vecs[v].lead, vecs[v].sgl, vecs[v].ch, DATA_W, $sformatf("vec%0d", v));
    end

    // abort after six data bits, then a clean frame straight after
    rand_bus();
    set_ch(5, 12'hA5C);
    exp_q.push_back(12'hA5C);
    run_frame(0, 1'b1, 5, 6, "abort");
    rand_bus();
    set_ch(7, 12'h001);
    exp_q.push_back(12'h001);
    run_frame(0, 1'b1, 7, DATA_W, "after_abort");

    // reset during data phase
    rand_bus();
    set_ch(1, 12'h5A5);
    d0 = done_cnt;
    e0 = err_cnt;
    spi_if.cs_n = 1'b0;
    repeat (4) @(negedge clk);
    send_cmd(0, 1'b1, 1);
    for (int i = 0; i < 6; i++) pulse(1'b0, q);
    rst_n = 1'b0;
    #1;
    check("midrst dout", 32'(spi_if.dout), 32'd0);
    check("midrst oe", 32'(spi_if.dout_oe), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst last_ch", 32'(last_ch), 32'd0);
    check("midrst last_sgl", 32'(last_sgl), 32'd0);
    check("midrst flags", 32'({frame_done, frame_err}), 32'd0);
    spi_if.cs_n = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("midrst no pulses", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
    check("midrst busy after", 32'(busy), 32'd0);
    exp_q.push_back(model(sample_bus, 1'b1, 1));
    run_frame(0, 1'b1, 1, DATA_W, "after_rst");

    // random frames against the model
    for (int n = 0; n < 20; n++) begin
      rand_bus();
      lead = $urandom_range(0, 2);
      sgl  = 1'($urandom_range(0, 1));
      ch   = $urandom_range(0, NCH - 1);
      exp_q.push_back(model(sample_bus, sgl, ch));
      run_frame(lead, sgl, ch, DATA_W, $sformatf("rnd%0d", n));
    end

    check("exp_q drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
